// File: rtl/cp0_irq_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : cp0_irq_scheduler
// Purpose  : CP0 timer / interrupt controller beside the dual-issue writeback
//            stage. Owns Count, Compare and Cause.TI. Synchronises the
//            external interrupt lines and decides when a pending, enabled
//            interrupt is injected into the committing group. Writeback sees
//            that decision as a take/flush handshake.
// Options  : CP0_COUNT_HALFRATE_EN - when defined, Count advances every second
//            cycle. An internal toggle flop sets the pace. Reset and any MTC0
//            Count write clear the toggle.
// Ports    : clk, resetn (async assert, active-low)
//            ext_int[5:0]     raw external lines (asynchronous to clk)
//            status_ie/exl/im CP0 Status fields
//            mtc0_valid/sel/wdata  committed MTC0 (0=Count 1=Compare
//                                  2=Cause.IP[1:0] from wdata[9:8], 3=none)
//            commit_valid/pc/blocked  group retiring in writeback
//            count, compare, cause_ip, cause_ti  CP0 register views
//            irq_pending (comb), irq_take (comb pulse), irq_epc, flush
// Revision : 1.0 - initial release
// ============================================================================
module cp0_irq_scheduler #(
    parameter int SYNC_STAGES  = 2,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [5:0]  ext_int,
    input  logic        status_ie,
    input  logic        status_exl,
    input  logic [7:0]  status_im,
    input  logic        mtc0_valid,
    input  logic [1:0]  mtc0_sel,
    input  logic [31:0] mtc0_wdata,
    input  logic        commit_valid,
    input  logic [31:0] commit_pc,
    input  logic        commit_blocked,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic [7:0]  cause_ip,
    output logic        cause_ti,
    output logic        irq_pending,
    output logic        irq_take,
    output logic [31:0] irq_epc,
    output logic        flush
);

    localparam logic [3:0] c_FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_drain_cnt;
    logic [3:0]  w_drain_cnt_nxt;
    logic        w_take;

    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic        r_ti;
    logic [1:0]  r_soft_ip;
    logic [31:0] r_epc;
    logic [SYNC_STAGES*6-1:0] r_sync_chain;

    logic [5:0]  w_sync_int;
    logic [31:0] w_count_inc;
    logic        w_tick;
    logic        w_wr_count;
    logic        w_wr_compare;
    logic        w_wr_ip;

    assign w_wr_count   = mtc0_valid && (mtc0_sel == 2'd0);
    assign w_wr_compare = mtc0_valid && (mtc0_sel == 2'd1);
    assign w_wr_ip      = mtc0_valid && (mtc0_sel == 2'd2);

    // ------------------------------------------------------------------
    // External interrupt synchroniser. It is a plain shift chain with the
    // newest sample at the low end and the output taken from the top stage.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sync_chain <= '0;
        end else begin
            r_sync_chain <= {r_sync_chain[(SYNC_STAGES-1)*6-1:0], ext_int};
        end
    end

    assign w_sync_int = r_sync_chain[SYNC_STAGES*6-1 -: 6];

    // ------------------------------------------------------------------
    // Count tick generation
    // ------------------------------------------------------------------
`ifdef CP0_COUNT_HALFRATE_EN
    logic r_half;

    // A Count write restarts the phase, so the first tick after the write
    // lands two cycles later.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_half <= 1'b0;
        end else if (w_wr_count) begin
            r_half <= 1'b0;
        end else begin
            r_half <= ~r_half;
        end
    end

    assign w_tick = r_half;
`else
    assign w_tick = 1'b1;
`endif

    assign w_count_inc = r_count + 32'd1;

    // ------------------------------------------------------------------
    // Count / Compare / TI / software IP bits
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_count   <= '0;
            r_compare <= '0;
            r_ti      <= 1'b0;
            r_soft_ip <= '0;
        end else begin
            if (w_wr_count) begin
                r_count <= mtc0_wdata;
            end else if (w_tick) begin
                r_count <= w_count_inc;
            end

            if (w_wr_compare) begin
                r_compare <= mtc0_wdata;
            end

            // A Compare write acknowledges the timer. It wins over a match
            // in the same cycle. A Count write suppresses the increment, so
            // no match can come from that cycle.
            if (w_wr_compare) begin
                r_ti <= 1'b0;
            end else if (w_tick && !w_wr_count && (w_count_inc == r_compare)) begin
                r_ti <= 1'b1;
            end

            if (w_wr_ip) begin
                r_soft_ip <= mtc0_wdata[9:8];
            end
        end
    end

    assign cause_ip    = {w_sync_int[5] | r_ti, w_sync_int[4:0], r_soft_ip};
    assign irq_pending = (|(cause_ip & status_im)) & status_ie & ~status_exl;

    // ------------------------------------------------------------------
    // Take / drain FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_drain_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_drain_cnt <= w_drain_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_drain_cnt_nxt = r_drain_cnt;
        w_take          = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (irq_pending) begin
                    w_state_nxt = ST_ARMED;
                end
            end
            ST_ARMED: begin
                // Status is a registered CP0 view. An MTC0 that sets EXL
                // reaches status_exl only after its own commit cycle, so it
                // cannot withdraw a take that is already in progress.
                if (!irq_pending) begin
                    w_state_nxt = ST_IDLE;
                end else if (commit_valid && !commit_blocked) begin
                    w_take          = 1'b1;
                    w_state_nxt     = ST_DRAIN;
                    w_drain_cnt_nxt = c_FLUSH_LOAD;
                end
            end
            ST_DRAIN: begin
                if (r_drain_cnt == 4'd0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_drain_cnt_nxt = r_drain_cnt - 4'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // EPC is presented combinationally in the take cycle and held afterwards.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_epc <= '0;
        end else if (w_take) begin
            r_epc <= commit_pc;
        end
    end

    assign irq_take = w_take;
    assign irq_epc  = w_take ? commit_pc : r_epc;
    assign flush    = (r_state == ST_DRAIN);
    assign count    = r_count;
    assign compare  = r_compare;
    assign cause_ti = r_ti;

endmodule
`default_nettype wire

// File: tb/tb_cp0_irq_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_cp0_irq_scheduler
// Purpose  : Self-checking bench for cp0_irq_scheduler. It covers a vector
//            table for the soft-interrupt handshake, hand-written timer, block,
//            ext-line and reset sequences, and randomised traffic checked
//            every cycle against a behavioural model. Honours
//            CP0_COUNT_HALFRATE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cp0_irq_scheduler;

    localparam int SYNC_STAGES  = 2;
    localparam int FLUSH_CYCLES = 2;
`ifdef CP0_COUNT_HALFRATE_EN
    localparam int C_TI_EDGES   = 10;
    localparam int C_TICK_EDGES = 2;
`else
    localparam int C_TI_EDGES   = 5;
    localparam int C_TICK_EDGES = 1;
`endif

    logic        clk;
    logic        resetn;
    logic [5:0]  ext_int;
    logic        status_ie;
    logic        status_exl;
    logic [7:0]  status_im;
    logic        mtc0_valid;
    logic [1:0]  mtc0_sel;
    logic [31:0] mtc0_wdata;
    logic        commit_valid;
    logic [31:0] commit_pc;
    logic        commit_blocked;
    logic [31:0] count;
    logic [31:0] compare;
    logic [7:0]  cause_ip;
    logic        cause_ti;
    logic        irq_pending;
    logic        irq_take;
    logic [31:0] irq_epc;
    logic        flush;

    cp0_irq_scheduler #(
        .SYNC_STAGES  (SYNC_STAGES),
        .FLUSH_CYCLES (FLUSH_CYCLES)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .ext_int        (ext_int),
        .status_ie      (status_ie),
        .status_exl     (status_exl),
        .status_im      (status_im),
        .mtc0_valid     (mtc0_valid),
        .mtc0_sel       (mtc0_sel),
        .mtc0_wdata     (mtc0_wdata),
        .commit_valid   (commit_valid),
        .commit_pc      (commit_pc),
        .commit_blocked (commit_blocked),
        .count          (count),
        .compare        (compare),
        .cause_ip       (cause_ip),
        .cause_ti       (cause_ti),
        .irq_pending    (irq_pending),
        .irq_take       (irq_take),
        .irq_epc        (irq_epc),
        .flush          (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural reference model
    // ------------------------------------------------------------------
    bit [31:0] m_count;
    bit [31:0] m_compare;
    bit        m_ti;
    bit [1:0]  m_sw;
    bit [5:0]  m_hist[$];     // front = value currently seen as sync_int
    bit        m_armed;       // interrupt latched, waiting for a commit
    int        m_drain;       // flush cycles still to run
    bit [31:0] m_epc;
    bit        m_phase;       // half-rate cadence: ticks on odd phase

    function automatic void model_reset();
        m_count = 0; m_compare = 0; m_ti = 0; m_sw = 0;
        m_armed = 0; m_drain = 0; m_epc = 0; m_phase = 0;
        m_hist.delete();
        for (int i = 0; i < SYNC_STAGES; i++) m_hist.push_back(6'd0);
    endfunction

    function automatic bit m_tick();
`ifdef CP0_COUNT_HALFRATE_EN
        return m_phase;
`else
        return 1'b1;
`endif
    endfunction

    function automatic bit [7:0] m_cause_ip();
        bit [5:0] s;
        s = m_hist[0];
        return {s[5] | m_ti, s[4:0], m_sw};
    endfunction

    function automatic bit m_pending();
        return (|(m_cause_ip() & status_im)) && status_ie && !status_exl;
    endfunction

    function automatic bit m_take();
        return m_armed && m_drain == 0 && m_pending() && commit_valid && !commit_blocked;
    endfunction

    function automatic void model_update();
        bit pend, take, tick, wr_cnt, wr_cmp, wr_ip;
        if (!resetn) begin
            model_reset();
            return;
        end
        pend   = m_pending();
        take   = m_take();
        tick   = m_tick();
        wr_cnt = mtc0_valid && mtc0_sel == 2'd0;
        wr_cmp = mtc0_valid && mtc0_sel == 2'd1;
        wr_ip  = mtc0_valid && mtc0_sel == 2'd2;

        if (m_drain > 0) begin
            m_drain--;
        end else if (m_armed) begin
            if (take) begin
                m_armed = 0;
                m_drain = FLUSH_CYCLES;
                m_epc   = commit_pc;
            end else if (!pend) begin
                m_armed = 0;
            end
        end else if (pend) begin
            m_armed = 1;
        end

        if (wr_cmp) m_ti = 0;
        else if (tick && !wr_cnt && (m_count + 32'd1) == m_compare) m_ti = 1;
        if (wr_cmp) m_compare = mtc0_wdata;
        if (wr_cnt) m_count = mtc0_wdata;
        else if (tick) m_count = m_count + 32'd1;
        m_phase = wr_cnt ? 1'b0 : ~m_phase;
        if (wr_ip) m_sw = mtc0_wdata[9:8];

        m_hist.push_back(ext_int);
        void'(m_hist.pop_front());
    endfunction

    task automatic check_all();
        chk("count",    count,                m_count);
        chk("compare",  compare,              m_compare);
        chk("cause_ip", 32'(cause_ip),        32'(m_cause_ip()));
        chk("cause_ti", 32'(cause_ti),        32'(m_ti));
        chk("pending",  32'(irq_pending),     32'(m_pending()));
        chk("take",     32'(irq_take),        32'(m_take()));
        chk("epc",      irq_epc,              m_take() ? commit_pc : m_epc);
        chk("flush",    32'(flush),           32'(m_drain > 0));
    endtask

    // Inputs are set just after a rising edge. Checks run mid-cycle and the
    // model advances on the edge.
    task automatic step();
        #2;
        check_all();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle_in();
        mtc0_valid = 0; mtc0_sel = 0; mtc0_wdata = 0;
        commit_valid = 0; commit_blocked = 0; commit_pc = 0;
    endtask

    task automatic mtc0(input logic [1:0] sel, input logic [31:0] wd);
        idle_in();
        mtc0_valid = 1; mtc0_sel = sel; mtc0_wdata = wd;
        step();
        idle_in();
    endtask

    // ------------------------------------------------------------------
    // Vector table
    // ------------------------------------------------------------------
    typedef struct {
        logic        mv;
        logic [1:0]  sel;
        logic [31:0] wd;
        logic        cv;
        logic        cb;
        logic [31:0] pc;
        logic [7:0]  im;
        logic        ie;
        logic        exl;
        logic        e_pend;
        logic        e_take;
        logic        e_flush;
        logic [31:0] e_epc;
    } vec_t;

    vec_t tbl[17];

    task automatic row(input int i, input logic mv, input logic [1:0] sel, input logic [31:0] wd,
                       input logic cv, input logic cb, input logic [31:0] pc,
                       input logic [7:0] im, input logic ie, input logic exl,
                       input logic ep, input logic et, input logic ef, input logic [31:0] ee);
        tbl[i] = '{mv, sel, wd, cv, cb, pc, im, ie, exl, ep, et, ef, ee};
    endtask

    localparam logic [31:0] PC0 = 32'hBFC0_0100;

    initial begin
        bit found;

        resetn = 0; ext_int = 0; status_ie = 1; status_exl = 0; status_im = 0;
        idle_in();
        model_reset();
        #1;
        chk("rst_count",   count,            32'd0);
        chk("rst_compare", compare,          32'd0);
        chk("rst_ti",      32'(cause_ti),    32'd0);
        chk("rst_ip",      32'(cause_ip),    32'd0);
        chk("rst_take",    32'(irq_take),    32'd0);
        chk("rst_epc",     irq_epc,          32'd0);
        chk("rst_flush",   32'(flush),       32'd0);
        @(posedge clk); #1;
        step();
        resetn = 1;

        // Soft-interrupt handshake (compare=0 and IM[7]=0 keep the timer out)
        row( 0,1'b0,2'd0,32'h0,       1'b0,1'b0,32'h0,        8'h01,1'b1,1'b0, 1'b0,1'b0,1'b0,32'h0);
        row( 1,1'b1,2'd2,32'h100,     1'b0,1'b0,32'h0,        8'h01,1'b1,1'b0, 1'b0,1'b0,1'b0,32'h0);
        row( 2,1'b0,2'd0,32'h0,       1'b1,1'b0,32'h1111_0000,8'h01,1'b1,1'b0, 1'b1,1'b0,1'b0,32'h0);
        row( 3,1'b0,2'd0,32'h0,       1'b1,1'b1,32'h2222_0000,8'h01,1'b1,1'b0, 1'b1,1'b0,1'b0,32'h0);
        row( 4,1'b0,2'd0,32'h0,       1'b1,1'b0,PC0,          8'h01,1'b1,1'b0, 1'b1,1'b1,1'b0,PC0);
        row( 5,1'b0,2'd0,32'h0,       1'b1,1'b0,32'h3333_0000,8'h01,1'b1,1'b0, 1'b1,1'b0,1'b1,PC0);
        row( 6,1'b0,2'd0,32'h0,       1'b1,1'b0,32'h3333_0004,8'h01,1'b1,1'b0, 1'b1,1'b0,1'b1,PC0);
        row( 7,1'b0,2'd0,32'h0,       1'b0,1'b0,32'h0,        8'h01,1'b1,1'b0, 1'b1,1'b0,1'b0,PC0);
        row( 8,1'b1,2'd2,32'h0,       1'b0,1'b0,32'h0,        8'h01,1'b1,1'b0, 1'b1,1'b0,1'b0,PC0);
        row( 9,1'b0,2'd0,32'h0,       1'b0,1'b0,32'h0,        8'h01,1'b1,1'b0, 1'b0,1'b0,1'b0,PC0);
        row(10,1'b0,2'd0,32'h0,       1'b1,1'b0,32'h4444_0000,8'h01,1'b1,1'b0, 1'b0,1'b0,1'b0,PC0);
        row(11,1'b1,2'd3,32'hFFFF_FFFF,1'b1,1'b0,32'h5555_0000,8'h01,1'b1,1'b0,1'b0,1'b0,1'b0,PC0);
        row(12,1'b0,2'd0,32'h0,       1'b0,1'b0,32'h0,        8'h01,1'b1,1'b0, 1'b0,1'b0,1'b0,PC0);
        row(13,1'b1,2'd2,32'h200,     1'b0,1'b0,32'h0,        8'h02,1'b1,1'b1, 1'b0,1'b0,1'b0,PC0);
        row(14,1'b0,2'd0,32'h0,       1'b0,1'b0,32'h0,        8'h02,1'b1,1'b1, 1'b0,1'b0,1'b0,PC0);
        row(15,1'b0,2'd0,32'h0,       1'b0,1'b0,32'h0,        8'h02,1'b0,1'b0, 1'b0,1'b0,1'b0,PC0);
        row(16,1'b0,2'd0,32'h0,       1'b0,1'b0,32'h0,        8'h02,1'b1,1'b0, 1'b1,1'b0,1'b0,PC0);

        for (int i = 0; i < 17; i++) begin
            mtc0_valid = tbl[i].mv; mtc0_sel = tbl[i].sel; mtc0_wdata = tbl[i].wd;
            commit_valid = tbl[i].cv; commit_blocked = tbl[i].cb; commit_pc = tbl[i].pc;
            status_im = tbl[i].im; status_ie = tbl[i].ie; status_exl = tbl[i].exl;
            #1;
            chk($sformatf("tbl%0d_pend", i),  32'(irq_pending), 32'(tbl[i].e_pend));
            chk($sformatf("tbl%0d_take", i),  32'(irq_take),    32'(tbl[i].e_take));
            chk($sformatf("tbl%0d_flush", i), 32'(flush),       32'(tbl[i].e_flush));
            chk($sformatf("tbl%0d_epc", i),   irq_epc,          tbl[i].e_epc);
            step();
        end
        idle_in();

        // Timer match: Compare=5, Count=0, IM[7]
        status_im = 8'h80; status_ie = 1; status_exl = 0;
        mtc0(2'd2, 32'h0);
        mtc0(2'd1, 32'd5);
        mtc0(2'd0, 32'd0);
        for (int i = 1; i < C_TI_EDGES; i++) begin
            step();
            chk("ti_early", 32'(cause_ti), 32'd0);
        end
        step();
        chk("ti_count", count, 32'd5);
        chk("ti_set",   32'(cause_ti), 32'd1);
        step();
        commit_valid = 1; commit_pc = PC0; #1;
        chk("ti_take", 32'(irq_take), 32'd1);
        chk("ti_epc",  irq_epc, PC0);
        step();
        idle_in();
        chk("flush_c1", 32'(flush), 32'd1);
        step();
        chk("flush_c2", 32'(flush), 32'd1);
        step();
        chk("flush_end", 32'(flush), 32'd0);

        // Blocked commits hold the take off (TI remains set)
        step();
        for (int i = 0; i < 3; i++) begin
            commit_valid = 1; commit_blocked = 1; commit_pc = 32'h8000_1000; #1;
            chk("blk_notake", 32'(irq_take), 32'd0);
            step();
        end
        commit_blocked = 0; #1;
        chk("blk_take", 32'(irq_take), 32'd1);
        chk("blk_epc",  irq_epc, 32'h8000_1000);
        step();
        idle_in();
        step(); step();

        // Compare write in the same cycle as a match clears TI
        mtc0(2'd0, 32'd2);
        found = 0;
        for (int k = 0; k < 12 && !found; k++) begin
            if (m_tick() && (m_count + 32'd1) == m_compare) found = 1;
            else step();
        end
        chk("match_search", 32'(found), 32'd1);
        mtc0(2'd1, 32'd100);
        chk("clr_ti",    32'(cause_ti), 32'd0);
        chk("clr_count", count, 32'd5);
        for (int i = 0; i < 4; i++) begin
            commit_valid = 1; commit_pc = 32'h8000_2000; #1;
            chk("clr_notake", 32'(irq_take), 32'd0);
            chk("clr_nopend", 32'(irq_pending), 32'd0);
            step();
        end
        idle_in();

        // External line through the synchroniser, withdrawn while ARMED
        status_im = 8'h10;
        ext_int = 6'b000100;
        step(); step();
        chk("ext_ip4", 32'(cause_ip[4]), 32'd1);
        step(); step();
        ext_int = 6'b0;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("ext_notake", 32'(irq_take), 32'd0);
            step();
        end
        chk("ext_withdrawn", 32'(irq_pending), 32'd0);
        chk("ext_noflush",   32'(flush), 32'd0);

        // Count wrap sets TI, then reset in the middle of DRAIN
        status_im = 8'h80;
        mtc0(2'd1, 32'h0);
        mtc0(2'd0, 32'hFFFF_FFFF);
        chk("wrap_pre", count, 32'hFFFF_FFFF);
        repeat (C_TICK_EDGES) step();
        chk("wrap_count", count, 32'd0);
        chk("wrap_ti",    32'(cause_ti), 32'd1);
        step();
        commit_valid = 1; commit_pc = 32'hBFC0_0200;
        step();
        idle_in();
        chk("drain_flush", 32'(flush), 32'd1);
        #2;
        resetn = 0;
        model_reset();
        #1;
        chk("arst_flush", 32'(flush), 32'd0);
        chk("arst_count", count, 32'd0);
        chk("arst_ti",    32'(cause_ti), 32'd0);
        chk("arst_epc",   irq_epc, 32'd0);
        step(); step();
        resetn = 1;

        // Randomised traffic against the model
        for (int c = 0; c < 1500; c++) begin
            if (!resetn) resetn = 1;
            else if ($urandom_range(0, 499) == 0) begin
                resetn = 0;
                model_reset();
            end
            if ($urandom_range(0, 9) == 0) ext_int = 6'($urandom);
            status_im  = 8'($urandom);
            status_ie  = ($urandom_range(0, 9) < 8);
            status_exl = ($urandom_range(0, 9) < 2);
            mtc0_valid = ($urandom_range(0, 99) < 8);
            mtc0_sel   = 2'($urandom);
            case (mtc0_sel)
                2'd0:    mtc0_wdata = m_compare - 32'($urandom_range(1, 12));
                2'd1:    mtc0_wdata = m_count + 32'($urandom_range(0, 12));
                default: mtc0_wdata = $urandom;
            endcase
            commit_valid   = ($urandom_range(0, 9) < 6);
            commit_blocked = ($urandom_range(0, 9) < 3);
            commit_pc      = $urandom;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cp0_irq_scheduler.md
# cp0_irq_scheduler

Controller for the CP0 timer and interrupt resources that the dual-issue writeback stage updates. It owns Count/Compare/Cause.TI, synchronizes external interrupt lines, and decides when a pending enabled interrupt is injected into the committing instruction group. It uses a take/flush handshake with writeback. It sits beside the writeback stage; writeback consumes `irq_take`/`irq_epc` and reports commit groups back.

## Interface
- `SYNC_STAGES`, 2, flops in the `ext_int` synchronizer (≥2)
- `FLUSH_CYCLES`, 2, cycles `flush` stays high after a take (1..15)
- `clk`  in  1  clock
- `resetn`  in  1  reset; asynchronous assert, active-low
- `ext_int`  in  6  raw external interrupt lines, asynchronous to `clk`
- `status_ie`, `status_exl`  in  1 each  CP0 Status.IE / Status.EXL
- `status_im`  in  8  CP0 Status.IM
- `mtc0_valid`  in  1  committed MTC0 this cycle
- `mtc0_sel`  in  2  0=Count, 1=Compare, 2=Cause.IP[1:0] (wdata[9:8]), 3=ignored
- `mtc0_wdata`  in  32  MTC0 data
- `commit_valid`  in  1  writeback retires a group this cycle
- `commit_pc`  in  32  PC of the oldest instruction in that group
- `commit_blocked`  in  1  group holds an exception, ERET or MTC0
- `count`, `compare`  out  32 each  CP0 Count / Compare
- `cause_ip`  out  8  Cause.IP
- `cause_ti`  out  1  Cause.TI
- `irq_pending`  out  1  enabled interrupt pending (combinational)
- `irq_take`  out  1  inject interrupt on the current commit group
- `irq_epc`  out  32  EPC for the take; valid with `irq_take`
- `flush`  out  1  pipeline flush request

## Operation
- Interrupt sources:
  - `ext_int` passes through a SYNC_STAGES-deep synchronizer giving `sync_int`.
  - `cause_ip[7] = sync_int[5] | cause_ti`.
  - `cause_ip[6:2] = sync_int[4:0]`.
  - `cause_ip[1:0]` are software bits written by MTC0 sel 2.
- `irq_pending = |(cause_ip & status_im) & status_ie & ~status_exl`.
- Count increments by 1 each tick and wraps from 32'hFFFF_FFFF to 0.
- TI is set on the tick where the new Count equals `compare`.
- Priorities:
  - MTC0 Count replaces the increment that cycle.
  - MTC0 Compare loads `compare` and clears TI. Clear beats a same-cycle match.
  - TI stays set until Compare is written.
- FSM states:
  - IDLE:
    - `irq_pending` → ARMED.
  - ARMED:
    - `~irq_pending` → IDLE (interrupt withdrawn, no take).
    - `commit_valid & ~commit_blocked` → `irq_take`=1, `irq_epc`=`commit_pc`, → DRAIN. Writeback squashes the whole group.
    - Blocked or no commit → stay in ARMED.
  - DRAIN:
    - `flush`=1 for FLUSH_CYCLES cycles, counted down by an internal counter, then → IDLE.
    - `irq_pending` is ignored in DRAIN.
- `irq_take` is combinational from state ARMED and the commit inputs; it is a single-cycle pulse.
- `irq_epc` holds its last take value between takes.

## Timing
- Reset values:
  - count=0, compare=0, cause_ti=0, cause_ip[1:0]=0, synchronizer flops=0.
  - FSM=IDLE, flush=0, irq_take=0, irq_epc=0.
- Reset mid-DRAIN aborts the flush immediately. Outputs take reset values asynchronously.
- External line to `cause_ip` latency is SYNC_STAGES cycles.
- MTC0 writes are visible on outputs the next cycle.
- Soft-bit write to pending is 1 cycle; pending to take is ≥1 cycle, since ARMED is entered first.
- Take to `flush` rise: next cycle. `flush` falls exactly FLUSH_CYCLES cycles later.
- An MTC0 to Status that sets EXL in the take cycle does not cancel the take.

## Configuration
- `CP0_COUNT_HALFRATE_EN`
  - Defined: a tick occurs every second cycle via an internal toggle flop. The toggle resets to 0, and an MTC0 Count write also clears it, so the first tick lands 2 cycles after the write.
  - Undefined: a tick occurs every cycle.

## Test plan
- Compare=5, Count=0, IM[7]=1, IE=1:
  - TI rises when count=5 (cycle 5; cycle 10 with halfrate).
  - Next cycle ARMED. First unblocked commit with pc 0xBFC0_0100 gives `irq_take`=1 and `irq_epc`=0xBFC0_0100.
  - `flush` then stays high 2 cycles.
- TI pending with `commit_blocked`=1 for 3 cycles, then 0 with commit_valid: no take during the blocked cycles, take on cycle 4.
- MTC0 Compare with TI=1 and a match on the same cycle: cause_ti=0 next cycle and no take.
- `ext_int[2]` pulse held 4 cycles, IM[4]=1: `cause_ip[4]`=1 two cycles later. Drop the line while ARMED with no commits: FSM returns to IDLE and `irq_take` never asserts.
- Count=32'hFFFF_FFFF, compare=0: Count wraps to 0 and TI sets. `resetn` low during DRAIN: flush=0 and count=0 immediately.
